// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the byte-serial IF/MEM memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam logic ResetEnable = 1'b1;
  localparam logic Stop        = 1'b1;

  // The reserved length code 11 is treated as a word access.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      LEN_W:   return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] len,
                                         input logic sgn);
    case (len)
      LEN_B:   return {{24{sgn & w[7]}}, w[7:0]};
      LEN_H:   return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and MEM-stage load/store onto a single
// byte-wide synchronous RAM port; MEM has priority and nothing is preempted.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic        mem_signed,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  state_e      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [31:0] ram_a_nx;
  logic [7:0]  ram_dout_nx;
  logic        ram_wr_nx, if_done_nx, mem_done_nx;
  logic [31:0] inst_nx, mem_rdata_nx;
  logic [31:0] rbuf, rbuf_nx, wbuf, wbuf_nx;
  logic [1:0]  len_q, len_nx;
  logic        sgn_q, sgn_nx;
  logic [2:0]  nbytes;
  logic [31:0] word;
  logic        mem_go, if_go;

  // A requester whose done is high this cycle is still holding its old req.
  assign mem_go = mem_req && !mem_done;
  assign if_go  = if_req && !if_done && !if_flush;

  assign nbytes = (state == IF_RD) ? 3'd4 : byte_count(len_q);
  // cnt is the index of the address on ram_a; ram_din carries byte cnt-1.
  assign word   = rbuf | ({24'd0, ram_din} << {cnt - 3'd1, 3'b000});

  assign stallreq_if  = (if_req && !if_done)   ? Stop : !Stop;
  assign stallreq_mem = (mem_req && !mem_done) ? Stop : !Stop;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    ram_a_nx     = ram_a;
    ram_dout_nx  = ram_dout;
    ram_wr_nx    = 1'b0;
    if_done_nx   = 1'b0;
    mem_done_nx  = 1'b0;
    inst_nx      = inst;
    mem_rdata_nx = mem_rdata;
    rbuf_nx      = rbuf;
    wbuf_nx      = wbuf;
    len_nx       = len_q;
    sgn_nx       = sgn_q;
    case (state)
      IDLE: begin
        if (mem_go) begin
          state_nx = mem_we ? MEM_WR : MEM_RD;
          cnt_nx   = 3'd0;
          ram_a_nx = mem_addr;
          rbuf_nx  = '0;
          wbuf_nx  = mem_wdata;
          len_nx   = mem_len;
          sgn_nx   = mem_signed;
          if (mem_we) begin
            ram_dout_nx = mem_wdata[7:0];
            ram_wr_nx   = 1'b1;
          end
        end else if (if_go) begin
          state_nx = IF_RD;
          cnt_nx   = 3'd0;
          ram_a_nx = if_addr;
          rbuf_nx  = '0;
        end
      end
      IF_RD, MEM_RD: begin
        if (state == IF_RD && if_flush) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt + 3'd1;
          if (cnt != 3'd0) rbuf_nx = word;
          if (cnt < nbytes - 3'd1) ram_a_nx = ram_a + 32'd1;
          if (cnt == nbytes) begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
            if (state == IF_RD) begin
              if_done_nx = 1'b1;
              inst_nx    = word;
            end else begin
              mem_done_nx  = 1'b1;
              mem_rdata_nx = extend(word, len_q, sgn_q);
            end
          end
        end
      end
      MEM_WR: begin
        if (cnt == nbytes - 3'd1) begin
          state_nx    = IDLE;
          cnt_nx      = 3'd0;
          mem_done_nx = 1'b1;
        end else begin
          cnt_nx      = cnt + 3'd1;
          ram_a_nx    = ram_a + 32'd1;
          ram_wr_nx   = 1'b1;
          ram_dout_nx = 8'(wbuf >> {cnt + 3'd1, 3'b000});
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == ResetEnable) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      inst      <= '0;
      mem_rdata <= '0;
      rbuf      <= '0;
      wbuf      <= '0;
      len_q     <= LEN_B;
      sgn_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ram_a     <= ram_a_nx;
      ram_dout  <= ram_dout_nx;
      ram_wr    <= ram_wr_nx;
      if_done   <= if_done_nx;
      mem_done  <= mem_done_nx;
      inst      <= inst_nx;
      mem_rdata <= mem_rdata_nx;
      rbuf      <= rbuf_nx;
      wbuf      <= wbuf_nx;
      len_q     <= len_nx;
      sgn_q     <= sgn_nx;
    end
  end

endmodule
